// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM among core_count cores.
// Latency: request seen in IDLE at cycle 0, RAM write/address in cycle 1, read data in cycle 2, ack in cycle 3.
// Backpressure: cores hold req/address/datain/wr until their one-cycle ack; peak one access per 3 cycles.
module data_mem_arbiter #(
  parameter int core_count = 2,
  parameter int addr_width = 12,
  parameter int mem_width  = 12,
  parameter int ptr_width  = (core_count > 1) ? $clog2(core_count) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [core_count-1:0]            req,
  input  logic [core_count-1:0]            wr,
  input  logic [addr_width*core_count-1:0] address,
  input  logic [mem_width*core_count-1:0]  datain,
  output logic [mem_width*core_count-1:0]  dataout,
  output logic [core_count-1:0]            ack,
  output logic [addr_width-1:0]            mem_addr,
  output logic [mem_width-1:0]             mem_din,
  output logic                             mem_wren,
  input  logic [mem_width-1:0]             mem_q,
  output logic                             busy,
  output logic [ptr_width-1:0]             grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                          state_q;
  logic [ptr_width-1:0]            rr_ptr_q;
  logic [ptr_width-1:0]            grant_q;
  logic                            wr_q;
  logic                            mem_wren_q;
  logic [addr_width-1:0]           mem_addr_q;
  logic [mem_width-1:0]            mem_din_q;
  logic [mem_width*core_count-1:0] dataout_q;
  logic [core_count-1:0]           ack_q;

  // A core being acked this cycle is masked so its still-held req is not granted again.
  logic [core_count-1:0] eligible;
  assign eligible = req & ~ack_q;

  logic                  sel_found_d;
  logic [ptr_width-1:0]  sel_idx_d;
  logic [addr_width-1:0] sel_addr_d;
  logic [mem_width-1:0]  sel_din_d;
  logic                  sel_wr_d;

  // Pick the first eligible core scanning upward from the round-robin pointer.
  always_comb begin
    int cand;
    cand        = 0;
    sel_found_d = 1'b0;
    sel_idx_d   = '0;
    sel_addr_d  = '0;
    sel_din_d   = '0;
    sel_wr_d    = 1'b0;
    for (int i = 0; i < core_count; i++) begin
      cand = (int'(rr_ptr_q) + i) % core_count;
      if (!sel_found_d && eligible[cand]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = ptr_width'(cand);
        sel_addr_d  = address[cand*addr_width +: addr_width];
        sel_din_d   = datain[cand*mem_width +: mem_width];
        sel_wr_d    = wr[cand];
      end
    end
  end

  // Pointer to the core after the one just served, wrapping at core_count.
  logic [ptr_width-1:0] rr_next_d;
  always_comb begin
    rr_next_d = '0;
    if (int'(grant_q) < core_count - 1) begin
      rr_next_d = grant_q + ptr_width'(1);
    end
  end

  // Access sequencer: IDLE latches the winner, ACCESS drives the RAM, RESP returns data and acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      wr_q       <= 1'b0;
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      dataout_q  <= '0;
      ack_q      <= '0;
    end else begin
      // Ack is a single-cycle pulse; only the RESP exit raises a bit.
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          mem_wren_q <= 1'b0;
          if (sel_found_d) begin
            grant_q    <= sel_idx_d;
            mem_addr_q <= sel_addr_d;
            mem_din_q  <= sel_din_d;
            wr_q       <= sel_wr_d;
            // Write enable is high exactly during the ACCESS cycle.
            mem_wren_q <= sel_wr_d;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wren_q <= 1'b0;
          state_q    <= RESP;
        end
        RESP: begin
          if (!wr_q) begin
            dataout_q[int'(grant_q)*mem_width +: mem_width] <= mem_q;
          end
          ack_q[grant_q] <= 1'b1;
          rr_ptr_q       <= rr_next_d;
          state_q        <= IDLE;
        end
        default: begin
          mem_wren_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign dataout  = dataout_q;
  assign ack      = ack_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_wren = mem_wren_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a 2-core instance driven by vector table and scoreboard,
// plus a 4-core instance for pointer-offset arbitration.
// Each instance talks to its own behavioural 1-cycle-latency RAM.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 2-core instance
  logic [1:0]  req, wr, ack;
  logic [23:0] address, datain, dataout;
  logic [11:0] mem_addr, mem_din, mem_q;
  logic        mem_wren, busy;
  logic [0:0]  grant_id;

  // 4-core instance
  logic [3:0]  req4, wr4, ack4;
  logic [47:0] address4, datain4, dataout4;
  logic [11:0] mem_addr4, mem_din4, mem_q4;
  logic        mem_wren4, busy4;
  logic [1:0]  grant_id4;

  data_mem_arbiter u_dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .address(address), .datain(datain),
    .dataout(dataout), .ack(ack), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy), .grant_id(grant_id)
  );

  data_mem_arbiter #(.core_count(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req4), .wr(wr4), .address(address4), .datain(datain4),
    .dataout(dataout4), .ack(ack4), .mem_addr(mem_addr4), .mem_din(mem_din4),
    .mem_wren(mem_wren4), .mem_q(mem_q4), .busy(busy4), .grant_id(grant_id4)
  );

  // Behavioural single-port RAMs, read data one cycle after the address.
  logic [11:0] ram  [0:4095];
  logic [11:0] ram4 [0:4095];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_din;
    mem_q <= ram[mem_addr];
    if (mem_wren4) ram4[mem_addr4] <= mem_din4;
    mem_q4 <= ram4[mem_addr4];
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected dataout of the acked core, pushed when a request is driven.
  typedef struct {
    int          core;
    logic [11:0] dout;
  } exp_t;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [11:0] ref_mem [0:4095];
  logic [11:0] model_dout [2];

  task automatic push_exp(input int core, input logic w, input logic [11:0] a, input logic [11:0] d);
    exp_t e;
    if (w) ref_mem[a] = d;
    else   model_dout[core] = ref_mem[a];
    e.core = core;
    e.dout = model_dout[core];
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && ack !== 2'b00) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", 32'(ack), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_ack_core", 32'(ack), 32'd1 << mon_e.core);
        check("sb_dataout", 32'(dataout[mon_e.core*12 +: 12]), 32'(mon_e.dout));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req = '0; wr = '0; req4 = '0; wr4 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_dout[0] = '0;
    model_dout[1] = '0;
    sb_q.delete();
  endtask

  // Single access on the 2-core DUT; called just after a negedge, returns at the ack negedge.
  task automatic do_access(input string name, input int core, input logic w,
                           input logic [11:0] a, input logic [11:0] d);
    int lat;
    int wren_cycles;
    bit got;
    lat = 0; wren_cycles = 0; got = 1'b0;
    address[core*12 +: 12] = a;
    datain[core*12 +: 12]  = d;
    wr[core]  = w;
    req[core] = 1'b1;
    push_exp(core, w, a, d);
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({name, "_wren_c1"}, 32'(mem_wren), 32'(w));
        check({name, "_mem_addr"}, 32'(mem_addr), 32'(a));
        check({name, "_mem_din"}, 32'(mem_din), 32'(d));
        check({name, "_grant"}, 32'(grant_id), 32'(core));
        check({name, "_busy"}, 32'(busy), 32'd1);
      end
      if (mem_wren) wren_cycles++;
      if (ack[core]) begin
        got = 1'b1;
        lat = k;
        req[core] = 1'b0;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_wren_cycles"}, 32'(wren_cycles), w ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    int          core;
    logic        w;
    logic [11:0] a;
    logic [11:0] d;
    logic [11:0] exp_dout;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, exp_g, nacks, n4, viol;
    bit [1:0] pend;

    tbl[0] = '{0, 1'b1, 12'h005, 12'hABC, 12'h111};
    tbl[1] = '{0, 1'b0, 12'h005, 12'h000, 12'hABC};
    tbl[2] = '{1, 1'b1, 12'h030, 12'h5A5, 12'h222};
    tbl[3] = '{1, 1'b0, 12'h030, 12'h000, 12'h5A5};
    tbl[4] = '{1, 1'b0, 12'h005, 12'h000, 12'hABC};
    tbl[5] = '{0, 1'b1, 12'hFFF, 12'h123, 12'hABC};
    tbl[6] = '{0, 1'b0, 12'hFFF, 12'h000, 12'h123};
    tbl[7] = '{1, 1'b0, 12'h010, 12'h000, 12'h111};
    tbl[8] = '{0, 1'b1, 12'h000, 12'hFFF, 12'h123};
    tbl[9] = '{0, 1'b0, 12'h000, 12'h000, 12'hFFF};

    for (int i = 0; i < 4096; i++) begin
      ram[i] = '0; ram4[i] = '0; ref_mem[i] = '0;
    end
    ram[12'h010] = 12'h111;  ram4[12'h010] = 12'h111;  ref_mem[12'h010] = 12'h111;
    ram[12'h020] = 12'h222;  ram4[12'h020] = 12'h222;  ref_mem[12'h020] = 12'h222;
    address = '0; datain = '0; address4 = '0; datain4 = '0;

    do_reset();

    // Reset state
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst4_busy", 32'(busy4), 32'd0);

    // Simultaneous reads from reset: core0 first, core1 three cycles later
    address[11:0] = 12'h010; address[23:12] = 12'h020; wr = 2'b00; req = 2'b11;
    push_exp(0, 1'b0, 12'h010, 12'h000);
    push_exp(1, 1'b0, 12'h020, 12'h000);
    t0 = 0; t1 = 0;
    for (int k = 1; k <= 12 && (t0 == 0 || t1 == 0); k++) begin
      @(negedge clk);
      if (k == 1) check("sim_grant_first", 32'(grant_id), 32'd0);
      if (k == 4) check("sim_grant_second", 32'(grant_id), 32'd1);
      if (ack[0] && t0 == 0) begin t0 = k; req[0] = 1'b0; end
      if (ack[1] && t1 == 0) begin t1 = k; req[1] = 1'b0; end
    end
    check("sim_ack0_cycle", 32'(t0), 32'd3);
    check("sim_ack1_cycle", 32'(t1), 32'd6);
    @(negedge clk);

    // Vector table of single accesses
    for (int i = 0; i < 10; i++) begin
      do_access($sformatf("vec%0d", i), tbl[i].core, tbl[i].w, tbl[i].a, tbl[i].d);
      check($sformatf("vec%0d_dataout", i), 32'(dataout[tbl[i].core*12 +: 12]), 32'(tbl[i].exp_dout));
      @(negedge clk);
    end

    // Continuous contention: grants alternate 0,1,0,1 in 12 cycles
    do_reset();
    address[11:0] = 12'h005; address[23:12] = 12'h030; wr = 2'b00; req = 2'b11;
    push_exp(0, 1'b0, 12'h005, 12'h000);
    push_exp(1, 1'b0, 12'h030, 12'h000);
    exp_g = 0; nacks = 0; pend = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (pend[c]) begin
          req[c] = 1'b1;
          push_exp(c, 1'b0, address[c*12 +: 12], 12'h000);
          pend[c] = 1'b0;
        end
      end
      if (ack != 2'b00) begin
        check("rr_grant_id", 32'(grant_id), 32'(exp_g));
        check("rr_ack", 32'(ack), 32'd1 << exp_g);
        for (int c = 0; c < 2; c++) begin
          if (ack[c]) begin req[c] = 1'b0; pend[c] = 1'b1; end
        end
        exp_g = 1 - exp_g;
        nacks++;
      end
    end
    check("rr_ack_count", 32'(nacks), 32'd4);
    for (int k = 0; k < 20 && (sb_q.size() != 0 || busy); k++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) if (ack[c]) req[c] = 1'b0;
    end
    check("rr_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);

    // Reset during ACCESS of a write
    address[11:0] = 12'h040; datain[11:0] = 12'h777; wr[0] = 1'b1; req[0] = 1'b1;
    @(negedge clk);
    check("rstmid_wren_before", 32'(mem_wren), 32'd1);
    reset = 1'b1; req = '0; wr = '0;
    @(negedge clk);
    check("rstmid_wren", 32'(mem_wren), 32'd0);
    check("rstmid_ack", 32'(ack), 32'd0);
    check("rstmid_dataout", 32'(dataout), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    model_dout[0] = '0; model_dout[1] = '0;
    sb_q.delete();
    @(negedge clk);
    do_access("post_rst", 1, 1'b0, 12'h010, 12'h000);
    check("post_rst_dataout", 32'(dataout[23:12]), 32'h111);
    @(negedge clk);

    // Four cores: move pointer to 2 by serving core1, then req=1010 serves core3 then core1
    address4[23:12] = 12'h010; address4[47:36] = 12'h020; wr4 = 4'b0000; req4 = 4'b0010;
    t0 = 0;
    for (int k = 1; k <= 10 && t0 == 0; k++) begin
      @(negedge clk);
      if (ack4 != 4'b0000) begin
        t0 = k;
        check("c4_setup_ack", 32'(ack4), 32'h2);
        req4 = 4'b0000;
      end
    end
    check("c4_setup_latency", 32'(t0), 32'd3);
    @(negedge clk);
    req4 = 4'b1010;
    n4 = 0;
    for (int k = 1; k <= 12 && n4 < 2; k++) begin
      @(negedge clk);
      if (ack4 != 4'b0000) begin
        if (n4 == 0) begin
          check("c4_first_ack", 32'(ack4), 32'h8);
          check("c4_first_cycle", 32'(k), 32'd3);
          check("c4_dout3", 32'(dataout4[47:36]), 32'h222);
          req4[3] = 1'b0;
        end else begin
          check("c4_second_ack", 32'(ack4), 32'h2);
          check("c4_second_cycle", 32'(k), 32'd6);
          check("c4_dout1", 32'(dataout4[23:12]), 32'h111);
          req4[1] = 1'b0;
        end
        n4++;
      end
    end
    check("c4_ack_count", 32'(n4), 32'd2);
    req4 = 4'b0000;
    viol = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy4 || mem_wren4) viol++;
    end
    check("c4_idle_quiet", 32'(viol), 32'd0);

    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
